// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: two-stage pipelined carry-lookahead subtractor.
// diff = a - b - borrow_in, computed as a + ~b + ~borrow_in.
// Stage 1 forms per-group carry-select sums and group G/P.
// Stage 2 runs the group carry chain, selects the sums and registers the flags.
module cla_sub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NGROUP = WIDTH / 4;

  // 4-bit lookahead adder: returns {carry_out, sum}
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic accept, s2_load, s1_adv;

  assign accept   = in_valid && in_ready;
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_load;
  assign in_ready = !s1_valid_q || s1_adv;
  assign out_valid = s2_valid_q;

  assign s1_valid_d = accept | (s1_valid_q & !s1_adv);
  assign s2_valid_d = s1_adv | (s2_valid_q & !out_ready);

  // Stage 1 combinational terms
  logic [WIDTH-1:0]           bp;
  logic [NGROUP-1:0][3:0]     sum0_d, sum1_d, sum0_q, sum1_q;
  logic [NGROUP-1:0]          gen_d, prop_d, gen_q, prop_q;
  logic                       a_msb_q, b_msb_q;

  assign bp = ~b;

  genvar gi;
  generate
    for (gi = 0; gi < NGROUP; gi++) begin : g_grp
      logic [4:0] r0;
      if (gi == 0) begin : g_first
        // Group 0 already knows its real carry-in, so one sum suffices.
        assign r0         = cla4(a[3:0], bp[3:0], ~borrow_in);
        assign sum0_d[gi] = r0[3:0];
        assign sum1_d[gi] = r0[3:0];
        assign gen_d[gi]  = r0[4];
        assign prop_d[gi] = 1'b0;
      end else begin : g_rest
        logic [4:0] r1;
        assign r0         = cla4(a[gi*4 +: 4], bp[gi*4 +: 4], 1'b0);
        assign r1         = cla4(a[gi*4 +: 4], bp[gi*4 +: 4], 1'b1);
        assign sum0_d[gi] = r0[3:0];
        assign sum1_d[gi] = r1[3:0];
        assign gen_d[gi]  = r0[4];
        // Carry out only with carry-in 1 means the whole group propagates.
        assign prop_d[gi] = r1[4] & ~r0[4];
      end
    end
  endgenerate

  // Stage 1 register: latch group sums, G/P and operand sign bits on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      sum0_q     <= '0;
      sum1_q     <= '0;
      gen_q      <= '0;
      prop_q     <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        sum0_q  <= sum0_d;
        sum1_q  <= sum1_d;
        gen_q   <= gen_d;
        prop_q  <= prop_d;
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
    end
  end

  // Stage 2 combinational: group carry chain, sum select, flags
  logic [NGROUP:0]  carry;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d, ovf_d, zero_d;

  always_comb begin
    carry    = '0;
    diff_d   = '0;
    carry[0] = 1'b0;
    for (int g = 0; g < NGROUP; g++) begin
      carry[g+1]       = gen_q[g] | (prop_q[g] & carry[g]);
      diff_d[g*4 +: 4] = carry[g] ? sum1_q[g] : sum0_q[g];
    end
    borrow_d = ~carry[NGROUP];
    ovf_d    = (a_msb_q != b_msb_q) && (diff_d[WIDTH-1] != a_msb_q);
    zero_d   = (diff_d == '0);
  end

  // Stage 2 register: results only change when a new item advances in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_adv) begin
        diff       <= diff_d;
        borrow_out <= borrow_d;
        overflow   <= ovf_d;
        zero       <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Bench for cla_sub_pipe: a 4-bit instance for directed vectors and pipeline
// corner cases, an 8-bit instance for randomized traffic against a reference model.
module tb_cla_sub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       v4_in_valid, v4_in_ready, v4_bin, v4_out_valid, v4_out_ready;
  logic [3:0] v4_a, v4_b, v4_diff;
  logic       v4_bo, v4_ov, v4_z;

  logic       v8_in_valid, v8_in_ready, v8_bin, v8_out_valid, v8_out_ready;
  logic [7:0] v8_a, v8_b, v8_diff;
  logic       v8_bo, v8_ov, v8_z;

  cla_sub_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
    .a(v4_a), .b(v4_b), .borrow_in(v4_bin), .out_valid(v4_out_valid),
    .out_ready(v4_out_ready), .diff(v4_diff), .borrow_out(v4_bo),
    .overflow(v4_ov), .zero(v4_z)
  );

  cla_sub_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .a(v8_a), .b(v8_b), .borrow_in(v8_bin), .out_valid(v8_out_valid),
    .out_ready(v8_out_ready), .diff(v8_diff), .borrow_out(v8_bo),
    .overflow(v8_ov), .zero(v8_z)
  );

  typedef struct packed {
    logic [7:0] diff;
    logic       bo;
    logic       ov;
    logic       z;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bo;
    logic       ov;
    logic       z;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int acc8   = 0;
  int out8   = 0;

  exp_t q4[$];
  exp_t q8[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer subtraction, unsigned borrow, signed range overflow
  function automatic exp_t model(input int w, input int a, input int b, input int bin);
    exp_t e;
    int r, sa, sb, sr, half, full;
    full   = 1 << w;
    half   = 1 << (w - 1);
    r      = a - b - bin;
    e.diff = 8'((r + full) % full);
    e.bo   = (r < 0);
    sa     = (a >= half) ? a - full : a;
    sb     = (b >= half) ? b - full : b;
    sr     = sa - sb - bin;
    e.ov   = (sr < -half) || (sr > half - 1);
    e.z    = (e.diff == 8'd0);
    return e;
  endfunction

  // Scoreboards: push on accept, pop and compare on output transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
      q8.delete();
    end else begin
      if (v4_out_valid && v4_out_ready) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL u4 output with nothing in flight: diff=%0h", v4_diff);
        end else begin
          exp_t e;
          e = q4.pop_front();
          checks--;
          chk("u4 scoreboard {diff,bo,ov,z}", {21'd0, 4'd0, v4_diff, v4_bo, v4_ov, v4_z},
              {21'd0, e});
        end
      end
      if (v4_in_valid && v4_in_ready)
        q4.push_back(model(4, int'(v4_a), int'(v4_b), int'(v4_bin)));
      if (v8_out_valid && v8_out_ready) begin
        out8++;
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL u8 output with nothing in flight: diff=%0h", v8_diff);
        end else begin
          exp_t e;
          e = q8.pop_front();
          checks--;
          chk("u8 scoreboard {diff,bo,ov,z}", {21'd0, v8_diff, v8_bo, v8_ov, v8_z},
              {21'd0, e});
        end
      end
      if (v8_in_valid && v8_in_ready) begin
        acc8++;
        q8.push_back(model(8, int'(v8_a), int'(v8_b), int'(v8_bin)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];
  exp_t ea;
  logic [3:0] held;

  initial begin
    vecs[0] = '{4'b0101, 4'b1001, 1'b0, 4'b1100, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{4'b0100, 4'b1010, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'b0001, 4'b0001, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    v4_in_valid = 0; v4_a = 0; v4_b = 0; v4_bin = 0; v4_out_ready = 1;
    v8_in_valid = 0; v8_a = 0; v8_b = 0; v8_bin = 0; v8_out_ready = 1;

    // Reset state
    repeat (2) tick();
    chk("reset out_valid", v4_out_valid, 0);
    chk("reset {diff,bo,ov,z}", {v4_diff, v4_bo, v4_ov, v4_z}, 0);
    chk("reset u8 out_valid", v8_out_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("in_ready after release", v4_in_ready, 1);

    // Directed vectors with latency check
    for (int i = 0; i < 9; i++) begin
      v4_a = vecs[i].a; v4_b = vecs[i].b; v4_bin = vecs[i].bin; v4_in_valid = 1;
      tick();
      v4_in_valid = 0;
      chk($sformatf("vec%0d out_valid after 1st edge", i), v4_out_valid, 0);
      tick();
      chk($sformatf("vec%0d out_valid after 2nd edge", i), v4_out_valid, 1);
      chk($sformatf("vec%0d {diff,bo,ov,z}", i), {v4_diff, v4_bo, v4_ov, v4_z},
          {vecs[i].diff, vecs[i].bo, vecs[i].ov, vecs[i].z});
      tick();
    end

    // Back-to-back 4 items at full rate
    for (int t = 0; t < 6; t++) begin
      if (t < 4) begin
        v4_a = 4'(2 * t + 5); v4_b = 4'(t); v4_bin = t[0]; v4_in_valid = 1;
      end else begin
        v4_in_valid = 0;
      end
      tick();
      chk($sformatf("b2b out_valid t%0d", t), v4_out_valid, (t >= 1 && t <= 4) ? 1 : 0);
    end
    repeat (2) tick();

    // Stall: out_ready low, second item waits in S1, third refused, outputs hold
    v4_out_ready = 0;
    v4_a = 4'b0011; v4_b = 4'b0110; v4_bin = 0; v4_in_valid = 1;
    ea = model(4, 3, 6, 0);
    tick();
    chk("stall in_ready after 1st accept", v4_in_ready, 1);
    v4_a = 4'b1010; v4_b = 4'b0010; v4_bin = 1;
    tick();
    chk("stall in_ready after 2nd accept", v4_in_ready, 0);
    chk("stall out_valid", v4_out_valid, 1);
    chk("stall diff first item", {v4_diff, v4_bo, v4_ov, v4_z}, {ea.diff[3:0], ea.bo, ea.ov, ea.z});
    held = v4_diff;
    v4_a = 4'b1111; v4_b = 4'b0000; v4_bin = 0;
    tick();
    chk("stall in_ready held low", v4_in_ready, 0);
    chk("stall diff stable", v4_diff, held);
    v4_a = 4'b0000; v4_b = 4'b1111;
    tick();
    chk("stall diff still stable", {v4_diff, v4_bo, v4_ov, v4_z}, {ea.diff[3:0], ea.bo, ea.ov, ea.z});
    v4_in_valid = 0; v4_out_ready = 1;
    repeat (3) tick();
    chk("drain out_valid low", v4_out_valid, 0);

    // Reset with both stages full
    v4_out_ready = 0;
    v4_a = 4'd9; v4_b = 4'd2; v4_bin = 0; v4_in_valid = 1;
    tick();
    v4_a = 4'd1; v4_b = 4'd8;
    tick();
    v4_in_valid = 0;
    chk("full pipe out_valid", v4_out_valid, 1);
    chk("full pipe in_ready", v4_in_ready, 0);
    rst_n = 0;
    v4_in_valid = 1;
    #1;
    chk("async reset out_valid", v4_out_valid, 0);
    chk("async reset {diff,bo,ov,z}", {v4_diff, v4_bo, v4_ov, v4_z}, 0);
    repeat (2) tick();
    v4_in_valid = 0;
    rst_n = 1;
    v4_out_ready = 1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("post-reset no stale out t%0d", t), v4_out_valid, 0);
      chk($sformatf("post-reset in_ready t%0d", t), v4_in_ready, 1);
    end

    // Randomized 8-bit traffic against the reference model
    begin
      int cyc;
      cyc = 0;
      while (acc8 < 1000 && cyc < 20000) begin
        v8_in_valid  = 1'($urandom_range(0, 1));
        v8_a         = 8'($urandom);
        v8_b         = 8'($urandom);
        v8_bin       = 1'($urandom_range(0, 1));
        v8_out_ready = ($urandom_range(0, 3) != 0);
        tick();
        cyc++;
      end
      v8_in_valid  = 0;
      v8_out_ready = 1;
      cyc = 0;
      while ((q8.size() != 0 || v8_out_valid) && cyc < 20) begin
        tick();
        cyc++;
      end
      tick();
    end
    chk("random accepted >= 1000", (acc8 >= 1000), 1);
    chk("random scoreboard empty", q8.size(), 0);
    chk("random outputs == accepts", out8, acc8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
